// File: rtl/enigma_pkg.sv
// ============================================================================
//  Package     : enigma_pkg
//  Description : Shared widths, alphabet constants, default notch positions,
//                stepper FSM state type and letter/position helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package enigma_pkg;

    localparam int LETTER_W = 5;
    localparam int ALPHABET = 26;

    // Highest legal rotate offset and the alphabet size as 5-bit values.
    localparam logic [LETTER_W-1:0] C_LAST_POS = 5'd25;
    localparam logic [LETTER_W-1:0] C_ALPHA_5  = 5'd26;

    // Default notch positions of the three rotors.
    localparam logic [LETTER_W-1:0] C_NOTCH1_DEF = 5'd16;
    localparam logic [LETTER_W-1:0] C_NOTCH2_DEF = 5'd4;
    localparam logic [LETTER_W-1:0] C_NOTCH3_DEF = 5'd21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // A keypress letter is legal when it encodes A..Z as 1..26.
    function automatic logic letter_ok(input logic [LETTER_W-1:0] l);
        return (l != '0) && (l <= C_ALPHA_5);
    endfunction

    // Fold a raw 5-bit start position into 0..25 (26..31 map to 0..5).
    function automatic logic [LETTER_W-1:0] reduce26(input logic [LETTER_W-1:0] v);
        return (v >= C_ALPHA_5) ? (v - C_ALPHA_5) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rotor_pos_ctr.sv
// ============================================================================
//  Module      : rotor_pos_ctr
//  Description : Mod-26 rotor position register with step enable, start
//                position load (26..31 folded to 0..5) and a notch compare
//                on the current (pre-step) position.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rotor_pos_ctr
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] NOTCH = C_NOTCH1_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_i,
    input  logic                load_i,
    input  logic [LETTER_W-1:0] load_val_i,
    output logic [LETTER_W-1:0] pos_o,
    output logic                at_notch_o
);

    logic [LETTER_W-1:0] pos_q;
    logic [LETTER_W-1:0] pos_d;

    // Next position: load beats step; a step wraps 25 back to 0.
    always_comb begin
        pos_d = pos_q;
        if (load_i) begin
            pos_d = reduce26(load_val_i);
        end else if (step_i) begin
            pos_d = (pos_q == C_LAST_POS) ? '0 : (pos_q + 5'd1);
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o      = pos_q;
    assign at_notch_o = (pos_q == NOTCH);

endmodule

`default_nettype wire

// File: rtl/rotor_stepper.sv
// ============================================================================
//  Module      : rotor_stepper
//  Description : Keypress front end of the rotor path. Captures one letter per
//                keypress, advances three rotor positions with odometer and
//                double-step carry, and presents letter plus post-step rotate
//                offsets to the rotor stages with a valid/ready handshake.
//                Optional build macro ROTOR_STEP_COUNT_EN adds a saturating
//                16-bit step counter output (step_count).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rotor_stepper
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] NOTCH1 = C_NOTCH1_DEF,
    parameter logic [LETTER_W-1:0] NOTCH2 = C_NOTCH2_DEF,
    parameter logic [LETTER_W-1:0] NOTCH3 = C_NOTCH3_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [LETTER_W-1:0] in_letter,
    output logic                in_ready,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_pos1,
    input  logic [LETTER_W-1:0] load_pos2,
    input  logic [LETTER_W-1:0] load_pos3,
    output logic [LETTER_W-1:0] rot1,
    output logic [LETTER_W-1:0] rot2,
    output logic [LETTER_W-1:0] rot3,
    output logic                out_valid,
    output logic [LETTER_W-1:0] out_letter,
    input  logic                out_ready
`ifdef ROTOR_STEP_COUNT_EN
    ,
    output logic [15:0]         step_count
`endif
);

    state_e              state_q;
    state_e              state_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic [LETTER_W-1:0] letter_q;
    logic [LETTER_W-1:0] letter_d;
    logic                w_step;

    logic                w_notch1;
    logic                w_notch2;
    logic                w_notch3;
    logic                w_unused_notch3;

    // Next state, letter capture and step strobe; load aborts everything.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        letter_d    = letter_q;
        w_step      = 1'b0;
        if (load) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Illegal letters are consumed here without stepping.
                    if (in_valid && letter_ok(in_letter)) begin
                        letter_d = in_letter;
                        state_d  = STEP;
                    end
                end
                STEP: begin
                    w_step      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, output valid and captured letter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            letter_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            letter_q    <= letter_d;
        end
    end

    // Carry decisions use pre-step positions; rotor2 double-steps on its own notch.
    rotor_pos_ctr #(.NOTCH(NOTCH1)) u_rotor1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (w_step),
        .load_i     (load),
        .load_val_i (load_pos1),
        .pos_o      (rot1),
        .at_notch_o (w_notch1)
    );

    rotor_pos_ctr #(.NOTCH(NOTCH2)) u_rotor2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (w_step && (w_notch1 || w_notch2)),
        .load_i     (load),
        .load_val_i (load_pos2),
        .pos_o      (rot2),
        .at_notch_o (w_notch2)
    );

    rotor_pos_ctr #(.NOTCH(NOTCH3)) u_rotor3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (w_step && w_notch2),
        .load_i     (load),
        .load_val_i (load_pos3),
        .pos_o      (rot3),
        .at_notch_o (w_notch3)
    );

    // Rotor3 notch would only matter to a fourth rotor, which does not exist.
    assign w_unused_notch3 = w_notch3;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_letter = letter_q;

`ifdef ROTOR_STEP_COUNT_EN
    logic [15:0] step_count_q;

    // Saturating count of STEP edges, cleared by load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count_q <= '0;
        end else if (load) begin
            step_count_q <= '0;
        end else if (w_step && (step_count_q != 16'hFFFF)) begin
            step_count_q <= step_count_q + 16'd1;
        end
    end

    assign step_count = step_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rotor_stepper.sv
// ============================================================================
//  Module      : tb_rotor_stepper
//  Description : Self-checking bench for rotor_stepper: directed vector table,
//                hand-written corner sequences and randomized keypresses
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rotor_stepper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_letter;
    logic       in_ready;
    logic       load;
    logic [4:0] load_pos1, load_pos2, load_pos3;
    logic [4:0] rot1, rot2, rot3;
    logic       out_valid;
    logic [4:0] out_letter;
    logic       out_ready;
`ifdef ROTOR_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    always #5 clk = ~clk;

    rotor_stepper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_letter  (in_letter),
        .in_ready   (in_ready),
        .load       (load),
        .load_pos1  (load_pos1),
        .load_pos2  (load_pos2),
        .load_pos3  (load_pos3),
        .rot1       (rot1),
        .rot2       (rot2),
        .rot3       (rot3),
        .out_valid  (out_valid),
        .out_letter (out_letter),
        .out_ready  (out_ready)
`ifdef ROTOR_STEP_COUNT_EN
        ,
        .step_count (step_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: rotor positions and step count as plain integers.
    int m1, m2, m3;
    int m_cnt;

    typedef struct {
        bit do_load;
        int p1, p2, p3;
        int letter;
        bit exp_v;
        int e1, e2, e3;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef ROTOR_STEP_COUNT_EN
        chk({name, " step_count"}, int'(step_count), m_cnt);
`else
        if (name.len() == 0) $display("unnamed count check");
`endif
    endtask

    function automatic bit model_letter_ok(input int l);
        return (l >= 1) && (l <= 26);
    endfunction

    // Odometer with double step, evaluated on pre-step positions.
    task automatic model_step();
        bit s2, s3;
        s2 = (m1 == 16) || (m2 == 4);
        s3 = (m2 == 4);
        m1 = (m1 + 1) % 26;
        if (s2) m2 = (m2 + 1) % 26;
        if (s3) m3 = (m3 + 1) % 26;
        if (m_cnt < 65535) m_cnt++;
    endtask

    task automatic do_load(input int a, input int b, input int c);
        @(negedge clk);
        load      = 1'b1;
        load_pos1 = 5'(a);
        load_pos2 = 5'(b);
        load_pos3 = 5'(c);
        @(negedge clk);
        load = 1'b0;
        m1 = a % 26; m2 = b % 26; m3 = c % 26;
        m_cnt = 0;
    endtask

    task automatic chk_rot(input string tag, input int e1, input int e2, input int e3);
        chk({tag, " rot1"}, int'(rot1), e1);
        chk({tag, " rot2"}, int'(rot2), e2);
        chk({tag, " rot3"}, int'(rot3), e3);
    endtask

    // One keypress with fixed two-edge latency, optional HOLD stall, then release.
    task automatic do_key(input string tag, input int letter, input bit exp_v,
                          input int e1, input int e2, input int e3, input int hold);
        @(negedge clk);
        chk({tag, " in_ready idle"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        in_letter = 5'(letter);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, int'(in_ready), exp_v ? 0 : 1);
        chk({tag, " out_valid early"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, " out_valid"}, int'(out_valid), int'(exp_v));
        chk_rot(tag, e1, e2, e3);
        if (exp_v) begin
            chk({tag, " out_letter"}, int'(out_letter), letter);
            chk_cnt(tag);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, " hold valid"}, int'(out_valid), 1);
                chk({tag, " hold letter"}, int'(out_letter), letter);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, " out_valid released"}, int'(out_valid), 0);
            chk({tag, " in_ready released"}, int'(in_ready), 1);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1, 0, 0, 0,    5, 1,  1, 0, 0};
        vecs[1]  = '{1, 15, 3, 0,   1, 1, 16, 3, 0};
        vecs[2]  = '{0, 0, 0, 0,    2, 1, 17, 4, 0};
        vecs[3]  = '{0, 0, 0, 0,    3, 1, 18, 5, 1};
        vecs[4]  = '{1, 25, 0, 0,   7, 1,  0, 0, 0};
        vecs[5]  = '{1, 16, 25, 0, 26, 1, 17, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,    0, 0, 17, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,   27, 0, 17, 0, 0};
        vecs[8]  = '{0, 0, 0, 0,   31, 0, 17, 0, 0};
        vecs[9]  = '{1, 28, 31, 26, 1, 1,  3, 5, 0};
        vecs[10] = '{1, 3, 4, 25,   9, 1,  4, 5, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_letter = '0; load = 1'b0;
        load_pos1 = '0; load_pos2 = '0; load_pos3 = '0; out_ready = 1'b0;
        m1 = 0; m2 = 0; m3 = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        chk_rot("reset", 0, 0, 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_letter", int'(out_letter), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", int'(in_ready), 1);
        chk_cnt("reset");

        // Directed vector table.
        for (int v = 0; v < 11; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            if (vecs[v].do_load) do_load(vecs[v].p1, vecs[v].p2, vecs[v].p3);
            do_key(tag, vecs[v].letter, vecs[v].exp_v, vecs[v].e1, vecs[v].e2, vecs[v].e3, 0);
        end

        // Step counter: three keys count up, load clears.
        do_load(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            model_step();
            do_key("cnt", k + 1, 1, m1, m2, m3, 0);
        end
        do_load(0, 0, 0);
        @(negedge clk);
        chk_cnt("cnt after load");

        // Long HOLD stall with ignored keypresses, then load aborts mid-HOLD.
        do_load(0, 0, 0);
        @(negedge clk); in_valid = 1'b1; in_letter = 5'd12;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_letter = 5'd20;
            @(negedge clk);
            chk("stall out_valid", int'(out_valid), 1);
            chk("stall out_letter", int'(out_letter), 12);
            chk("stall in_ready", int'(in_ready), 0);
            chk_rot("stall", 1, 0, 0);
        end
        in_valid = 1'b0;
        do_load(30, 2, 9);
        chk_rot("hold load", 4, 2, 9);
        chk("hold load out_valid", int'(out_valid), 0);
        chk("hold load in_ready", int'(in_ready), 1);
        chk_cnt("hold load");

        // Load and keypress in the same IDLE cycle: load wins.
        @(negedge clk);
        load = 1'b1; load_pos1 = 5'd7; load_pos2 = 5'd8; load_pos3 = 5'd9;
        in_valid = 1'b1; in_letter = 5'd3;
        @(negedge clk);
        load = 1'b0; in_valid = 1'b0;
        m1 = 7; m2 = 8; m3 = 9; m_cnt = 0;
        chk("coload in_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("coload out_valid", int'(out_valid), 0);
        chk_rot("coload", 7, 8, 9);

        // out_ready asserted outside HOLD must not shorten the handshake.
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_letter = 5'd6;
        @(negedge clk); in_valid = 1'b0;
        chk("early ready out_valid", int'(out_valid), 0);
        model_step();
        @(negedge clk);
        chk("early ready out_valid set", int'(out_valid), 1);
        chk_rot("early ready", m1, m2, m3);
        @(negedge clk);
        out_ready = 1'b0;
        chk("early ready released", int'(out_valid), 0);

        // Reset asserted while in STEP.
        do_load(1, 2, 3);
        @(negedge clk); in_valid = 1'b1; in_letter = 5'd4;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_rot("midreset", 0, 0, 0);
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset out_letter", int'(out_letter), 0);
        m1 = 0; m2 = 0; m3 = 0; m_cnt = 0;
        chk_cnt("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset in_ready", int'(in_ready), 1);
        chk("midreset no valid", int'(out_valid), 0);
        chk_rot("midreset after", 0, 0, 0);

        // Randomized keypresses against the reference model.
        for (int r = 0; r < 6; r++) begin
            do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)));
            for (int k = 0; k < 40; k++) begin
                int l;
                bit ok;
                if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(27, 31));
                else l = int'($urandom_range(1, 26));
                ok = model_letter_ok(l);
                if (ok) model_step();
                do_key($sformatf("rnd%0d_%0d", r, k), l, ok, m1, m2, m3,
                       int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
